// File: rtl/mem_arb_pkg.sv
// Shared types, funct3 size codes and the access-legality rule used by the
// data-memory port arbiter and its byte-lane helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef enum logic {
    REQ_CORE,
    REQ_ACC
  } req_id_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the access must be rejected: an unknown size code for the
  // direction, or a halfword/word that does not sit on its natural boundary.
  function automatic logic accessErr(input logic we, input logic [2:0] func3,
                                     input logic [1:0] addrLo);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = !((func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W));
    end else begin
      illegal = !((func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                  (func3 == F3_BU) || (func3 == F3_HU));
    end
    misaligned = ((func3[1:0] == 2'b01) && addrLo[0]) ||
                 ((func3[1:0] == 2'b10) && (addrLo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper: byte enables, store-data replication,
// load-data lane select with sign/zero extension, and the reject flag.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_memRdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [31:0] w_shifted;

  assign o_err     = accessErr(i_we, i_func3, i_addrLo);
  assign w_shifted = i_memRdata >> {i_addrLo, 3'b000};

  // Size field (func3[1:0]) picks the lane mask and how store data is spread.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    case (i_func3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addrLo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << i_addrLo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Lane already shifted down to bit 0; extend according to the load flavour.
  always_comb begin
    o_rdata = i_memRdata;
    case (i_func3)
      F3_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_rdata = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_rdata = {16'h0000, w_shifted[15:0]};
      default: o_rdata = i_memRdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester data-memory port arbiter (core = port 0, accelerator = port 1),
// one transaction in flight. Define MEM_ARB_RR_EN for round-robin arbitration;
// otherwise the core always wins a simultaneous request.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [2:0]    c_func3,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [2:0]    a_func3,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  state_t        r_state;
  state_t        w_next;
  req_id_t       r_id;
  req_id_t       w_winner;
  logic          r_we;
  logic [2:0]    r_func3;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_gntPend;
  logic [DW-1:0] r_cRdata;
  logic [DW-1:0] r_aRdata;

  logic          w_anyReq;
  logic          w_accept;
  logic          w_selWe;
  logic [2:0]    w_selFunc3;
  logic [AW-1:0] w_selAddr;
  logic [DW-1:0] w_selWdata;
  logic          w_selErr;
  logic          w_memReq;
  logic          w_rvalid;
  logic [3:0]    w_be;
  logic [DW-1:0] w_repWdata;
  logic [DW-1:0] w_fmtRdata;
  logic          w_alignErr;

`ifdef MEM_ARB_RR_EN
  req_id_t       r_prio;
`endif

  assign w_anyReq = c_req | a_req;
  assign w_accept = (r_state == IDLE) && w_anyReq;

  // Choose which requester is served when the FSM is ready for a new access.
  always_comb begin
    w_winner = REQ_CORE;
`ifdef MEM_ARB_RR_EN
    if (c_req && a_req) begin
      w_winner = r_prio;
    end else if (a_req) begin
      w_winner = REQ_ACC;
    end
`else
    if (!c_req && a_req) begin
      w_winner = REQ_ACC;
    end
`endif
  end

  // Route the winner's request fields toward the capture registers.
  always_comb begin
    w_selWe    = c_we;
    w_selFunc3 = c_func3;
    w_selAddr  = c_addr;
    w_selWdata = c_wdata;
    if (w_winner == REQ_ACC) begin
      w_selWe    = a_we;
      w_selFunc3 = a_func3;
      w_selAddr  = a_addr;
      w_selWdata = a_wdata;
    end
  end

  // Illegal accesses skip the memory entirely, so decide at capture time.
  assign w_selErr = accessErr(w_selWe, w_selFunc3, w_selAddr[1:0]);

  mem_lane_align u_align (
    .i_we       (r_we),
    .i_func3    (r_func3),
    .i_addrLo   (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_memRdata (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_repWdata),
    .o_rdata    (w_fmtRdata),
    .o_err      (w_alignErr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus memory request and response strobe. An error response
  // enters RESP while the grant is still pulsing, so it lingers one cycle
  // there before the rvalid pulse.
  always_comb begin
    w_next   = r_state;
    w_memReq = 1'b0;
    w_rvalid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_next = w_selErr ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_memReq = 1'b1;
        if (mem_ready) begin
          w_next = r_we ? RESP : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (!r_gntPend) begin
          w_rvalid = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the winning request, time the grant pulse and hold per-port read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id      <= REQ_CORE;
      r_we      <= 1'b0;
      r_func3   <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_gntPend <= 1'b0;
      r_cRdata  <= '0;
      r_aRdata  <= '0;
    end else begin
      r_gntPend <= w_accept;
      if (w_accept) begin
        r_id    <= w_winner;
        r_we    <= w_selWe;
        r_func3 <= w_selFunc3;
        r_addr  <= w_selAddr;
        r_wdata <= w_selWdata;
        if (w_selErr) begin
          if (w_winner == REQ_CORE) begin
            r_cRdata <= '0;
          end else begin
            r_aRdata <= '0;
          end
        end
      end
      if ((r_state == WAIT_RD) && mem_rvalid) begin
        if (r_id == REQ_CORE) begin
          r_cRdata <= w_fmtRdata;
        end else begin
          r_aRdata <= w_fmtRdata;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Hand priority to the other port once a response (error or not) completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= REQ_CORE;
    end else if (w_rvalid) begin
      r_prio <= (r_id == REQ_CORE) ? REQ_ACC : REQ_CORE;
    end
  end
`endif

  assign c_gnt    = r_gntPend && (r_id == REQ_CORE);
  assign a_gnt    = r_gntPend && (r_id == REQ_ACC);
  assign c_rvalid = w_rvalid && (r_id == REQ_CORE);
  assign a_rvalid = w_rvalid && (r_id == REQ_ACC);
  assign c_err    = c_rvalid && w_alignErr;
  assign a_err    = a_rvalid && w_alignErr;
  assign c_rdata  = r_cRdata;
  assign a_rdata  = r_aRdata;

  assign mem_req   = w_memReq;
  assign mem_we    = w_memReq && r_we;
  assign mem_addr  = w_memReq ? {r_addr[AW-1:2], 2'b00} : '0;
  assign mem_be    = w_memReq ? w_be : 4'b0000;
  assign mem_wdata = w_memReq ? w_repWdata : '0;

endmodule
